plot_sink: RTL and testbench
============================

# plot_sink

Receiving end of the display controllers' pixel-plot stream. Accepts the stream (`plot`, `x`, `y`, `color`) from the display mux and buffers plots in a small FIFO. Clips off-screen coordinates. Drains plots into the 160x120, 3-bit video framebuffer write port whenever the scan-out arbiter grants access. Also performs a full-screen clear sweep on request so the game can blank the screen between levels.

## Interface

Parameters:
- `FIFO_DEPTH`, 8: plot FIFO entries; power of two, 2..32.
- `SCREEN_W`, 160: visible width in pixels.
- `SCREEN_H`, 120: visible height in pixels.
- `CLEAR_COLOR`, 3'b000: colour written by a clear sweep.

Ports:
- `clk`, in, 1: single clock; all logic on posedge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `plot`, in, 1: plot request, one pixel per cycle while high.
- `x`, in, 8: pixel column.
- `y`, in, 8: pixel row.
- `color`, in, 3: pixel colour.
- `busy`, out, 1: combinational back-pressure; a plot is ignored in any cycle `busy`=1.
- `clear`, in, 1: start a clear sweep; sampled only in IDLE.
- `clear_done`, out, 1: one-cycle pulse when the sweep finishes.
- `mem_grant`, in, 1: framebuffer port available this cycle.
- `mem_we`, out, 1: registered write strobe.
- `mem_addr`, out, 15: registered address, `y*SCREEN_W + x`.
- `mem_data`, out, 3: registered write colour.
- `drop_count`, out, 8: saturating count of clipped plots (see Configuration).

## Operation

- FSM states: IDLE, CLEAR, FLUSH.
  - Reset state is IDLE.
  - IDLE→CLEAR when `clear`=1 and FIFO empty.
  - IDLE→FLUSH when `clear`=1 and FIFO not empty.
  - FLUSH→CLEAR once the FIFO empties.
  - CLEAR→IDLE after the write to the last address (19199 for defaults); `clear_done` pulses in that same cycle.
- `busy` = FIFO full OR state≠IDLE.
- Accept condition: `plot`=1 AND `busy`=0.
  - Accepted with `x`<`SCREEN_W` and `y`<`SCREEN_H`: push {x, y, color}.
  - Accepted with `x`>=`SCREEN_W` or `y`>=`SCREEN_H`: discard; `busy` is not raised for it.
- Drain (IDLE or FLUSH): when `mem_grant`=1 and FIFO not empty, pop the head and register `mem_we`=1, `mem_addr`, `mem_data`. Otherwise `mem_we`=0 next cycle.
- Clear sweep:
  - A 15-bit counter starts at 0 and advances only on cycles with `mem_grant`=1.
  - Each granted cycle registers `mem_we`=1, `mem_addr`=counter, `mem_data`=`CLEAR_COLOR`.
- Address arithmetic: `y*SCREEN_W + x` computed at 15 bits with no truncation; maximum value 19199.
- FIFO ordering: strict FIFO. Writes reach memory in acceptance order.
- Full FIFO: a push in the same cycle as a pop is still refused, because `busy` reflects the full state before the edge.
- `clear` asserted outside IDLE: ignored.
- Reset mid-operation:
  - FIFO emptied, FSM to IDLE, clear counter to 0.
  - Pending plots are lost; a partial sweep is abandoned.

## Timing

- Reset values: `mem_we`=0, `mem_addr`=0, `mem_data`=0, `clear_done`=0, `drop_count`=0. `busy`=0 after reset, since the FIFO is empty and the FSM is in IDLE.
- Plot accepted at edge E0; with `mem_grant`=1 it is popped at E1, and `mem_we`=1 is visible for the cycle after E1. Latency is 1 edge from acceptance to strobe; the memory samples at E2.
- Sustained throughput with `mem_grant` held high is one pixel per cycle. `busy` never asserts in that case.
- With `mem_grant`=0, the FIFO fills after `FIFO_DEPTH` accepted plots. `busy` rises combinationally in the cycle after the last push.
- Clear of the 160x120 screen under continuous grant: 19200 `mem_we` cycles. `clear_done` is asserted in the cycle carrying the address-19199 strobe.

## Configuration

Macro `PLOT_SINK_DROP_COUNT_EN`:
- Defined:
  - `drop_count` increments on every clipped plot that passes the accept condition.
  - It saturates at 255 and clears only on `reset`.
- Undefined:
  - `drop_count` is tied to 8'd0 and no counter logic is built.
  - Clipping behaviour is unchanged.

## Test plan

- Reset, then with `mem_grant`=1 plot (x=5, y=3, color=3'b110) → one `mem_we` pulse with `mem_addr`=485, `mem_data`=3'b110, one edge after acceptance.
- Hold `mem_grant`=0 and plot 8 pixels plus a 9th → `busy`=1 after the 8th and the 9th is ignored. Raise grant → exactly 8 writes, in order.
- Plot (x=160, y=0) then (x=0, y=120) → no writes and `busy` stays 0. `drop_count`=2 with the macro defined; 0 without it.
- Queue 3 plots with grant low, then pulse `clear` and raise grant → 3 plot writes, then addresses 0..19199 with `CLEAR_COLOR`. `clear_done` is a single pulse on the address-19199 write, then IDLE.
- Toggle `mem_grant` every other cycle during a clear → the address advances only on granted cycles, with no skipped or repeated addresses.
- Assert `reset` mid-sweep at address 1000 → outputs return to their reset values immediately (asynchronously). A new `clear` restarts from address 0.

Source files
------------

// File: rtl/plot_sink.sv
// plot_sink: receives the pixel-plot stream, clips off-screen pixels, buffers
// in-range plots in a small FIFO and drains them into the framebuffer write
// port when granted. A clear request sweeps every framebuffer address with
// CLEAR_COLOR.
// Optional feature: define PLOT_SINK_DROP_COUNT_EN to build the saturating
// clipped-plot counter; otherwise drop_count is tied to zero.
//
// state | meaning
// IDLE  | accept plots, drain FIFO on grant
// FLUSH | clear requested, draining remaining plots first
// CLEAR | sweeping all addresses with CLEAR_COLOR on granted cycles
module plot_sink #(
  parameter int         FIFO_DEPTH  = 8,
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        plot,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [2:0]  color,
  output logic        busy,
  input  logic        clear,
  output logic        clear_done,
  input  logic        mem_grant,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic [7:0]  drop_count
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [8:0]  W_LIM     = 9'(SCREEN_W);
  localparam logic [8:0]  H_LIM     = 9'(SCREEN_H);
  localparam logic [14:0] W15       = 15'(SCREEN_W);
  localparam logic [14:0] LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FLUSH} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_fx [FIFO_DEPTH];
  logic [7:0]  r_fy [FIFO_DEPTH];
  logic [2:0]  r_fc [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic [14:0] r_clr_cnt;
  logic        r_mem_we, r_clear_done;
  logic [14:0] r_mem_addr;
  logic [2:0]  r_mem_data;

  logic        w_empty, w_full, w_busy, w_accept, w_in_range, w_push, w_pop;
  logic        w_clr_wr, w_clr_last;
  logic [14:0] w_head_addr;

  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_busy     = w_full || (r_state != S_IDLE);
  assign w_accept   = plot && !w_busy;
  assign w_in_range = ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);
  assign w_push     = w_accept && w_in_range;
  assign w_pop      = (r_state != S_CLEAR) && mem_grant && !w_empty;
  assign w_clr_wr   = (r_state == S_CLEAR) && mem_grant;
  assign w_clr_last = w_clr_wr && (r_clr_cnt == LAST_ADDR);
  assign w_head_addr = 15'(r_fy[r_rptr[AW-1:0]]) * W15 + 15'(r_fx[r_rptr[AW-1:0]]);

  // FIFO storage: written on push, no reset needed for the data itself
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fx[r_wptr[AW-1:0]] <= x;
      r_fy[r_wptr[AW-1:0]] <= y;
      r_fc[r_wptr[AW-1:0]] <= color;
    end
  end

  // FIFO pointers, with an extra wrap bit to tell full from empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clear) w_state_nxt = w_empty ? S_CLEAR : S_FLUSH;
      S_FLUSH: if (w_empty) w_state_nxt = S_CLEAR;
      S_CLEAR: if (w_clr_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // clear sweep address counter, advancing only on granted cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_clr_cnt <= '0;
    else if (w_clr_last) r_clr_cnt <= '0;
    else if (w_clr_wr)   r_clr_cnt <= r_clr_cnt + 15'd1;
  end

  // registered framebuffer write port and sweep-done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_mem_we     <= w_pop || w_clr_wr;
      r_clear_done <= w_clr_last;
      if (w_pop) begin
        r_mem_addr <= w_head_addr;
        r_mem_data <= r_fc[r_rptr[AW-1:0]];
      end else if (w_clr_wr) begin
        r_mem_addr <= r_clr_cnt;
        r_mem_data <= CLEAR_COLOR;
      end
    end
  end

`ifdef PLOT_SINK_DROP_COUNT_EN
  logic [7:0] r_drop_cnt;

  // saturating count of accepted-but-clipped plots
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_drop_cnt <= '0;
    else if (w_accept && !w_in_range && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign drop_count = r_drop_cnt;
`else
  assign drop_count = 8'd0;
`endif

  assign busy       = w_busy;
  assign clear_done = r_clear_done;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_mem_data;

endmodule

// File: tb/tb_plot_sink.sv
// Directed bench for plot_sink: table of single-plot vectors plus hand-written
// sequences for FIFO full, flush-then-clear, gated clear and async reset.
module tb_plot_sink;

`ifdef PLOT_SINK_DROP_COUNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, plot, clear, mem_grant;
  logic [7:0]  x, y;
  logic [2:0]  color;
  logic        busy, clear_done, mem_we;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic [7:0]  drop_count;

  int n_chk  = 0;
  int n_fail = 0;

  plot_sink dut (
    .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .color(color),
    .busy(busy), .clear(clear), .clear_done(clear_done), .mem_grant(mem_grant),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  c;
    logic        exp_we;
    logic [14:0] exp_addr;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int errs, idx, pulses, exp_a;
    bit finished, prev_g;
    logic [14:0] plot_addr [3];

    vecs[0] = '{8'd5,   8'd3,   3'b110, 1'b1, 15'd485,   8'd0};
    vecs[1] = '{8'd0,   8'd0,   3'b001, 1'b1, 15'd0,     8'd0};
    vecs[2] = '{8'd160, 8'd0,   3'b010, 1'b0, 15'd0,     DROP_EN ? 8'd1 : 8'd0};
    vecs[3] = '{8'd0,   8'd120, 3'b011, 1'b0, 15'd0,     DROP_EN ? 8'd2 : 8'd0};
    vecs[4] = '{8'd159, 8'd119, 3'b111, 1'b1, 15'd19199, DROP_EN ? 8'd2 : 8'd0};
    vecs[5] = '{8'd255, 8'd255, 3'b101, 1'b0, 15'd0,     DROP_EN ? 8'd3 : 8'd0};
    vecs[6] = '{8'd10,  8'd100, 3'b100, 1'b1, 15'd16010, DROP_EN ? 8'd3 : 8'd0};

    reset = 1'b1; plot = 1'b0; clear = 1'b0; mem_grant = 1'b0;
    x = '0; y = '0; color = '0;
    repeat (2) @(negedge clk);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    mem_grant = 1'b1;

    // single plots with continuous grant: one strobe one edge after acceptance
    foreach (vecs[i]) begin
      @(negedge clk);
      plot = 1'b1; x = vecs[i].x; y = vecs[i].y; color = vecs[i].c;
      @(negedge clk);
      plot = 1'b0;
      chk("vec_busy", busy, 0);
      chk("vec_we_early", mem_we, 0);
      @(negedge clk);
      chk("vec_we", mem_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk("vec_addr", mem_addr, vecs[i].exp_addr);
        chk("vec_data", mem_data, vecs[i].c);
      end
      chk("vec_drop", drop_count, vecs[i].exp_drop);
      @(negedge clk);
      chk("vec_we_after", mem_we, 0);
    end

    // fill the FIFO with grant low; the ninth plot must be refused
    mem_grant = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("fill_busy", busy, 0);
      plot = 1'b1; x = 8'(i + 1); y = 8'd2; color = 3'(i);
    end
    @(negedge clk);
    chk("full_busy", busy, 1);
    x = 8'd50; y = 8'd50; color = 3'b111;
    @(negedge clk);
    plot = 1'b0;
    chk("full_busy_hold", busy, 1);
    chk("full_no_we", mem_we, 0);
    mem_grant = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("drain_we", mem_we, 1);
      chk("drain_addr", mem_addr, 321 + i);
      chk("drain_data", mem_data, i[2:0]);
    end
    @(negedge clk);
    chk("drain_end_we", mem_we, 0);
    chk("drain_end_busy", busy, 0);

    // three queued plots, then a clear: flush, then sweep 0..19199
    mem_grant = 1'b0;
    plot_addr[0] = 15'd161; plot_addr[1] = 15'd322; plot_addr[2] = 15'd483;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      plot = 1'b1; x = 8'(i); y = 8'(i); color = 3'(i);
    end
    @(negedge clk);
    plot = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("flush_busy", busy, 1);
    mem_grant = 1'b1;
    errs = 0; idx = 0; pulses = 0; finished = 1'b0;
    for (int cyc = 0; cyc < 25000 && !finished; cyc++) begin
      @(negedge clk);
      if (mem_we) begin
        if (idx < 3) begin
          if (mem_addr !== plot_addr[idx] || mem_data !== 3'(idx + 1)) errs++;
        end else begin
          if (mem_addr !== 15'(idx - 3) || mem_data !== 3'b000) errs++;
        end
        if (clear_done) begin
          pulses++;
          finished = 1'b1;
          if (idx != 3 + 19199) errs++;
        end
        idx++;
      end else if (clear_done) begin
        pulses++;
        errs++;
      end
    end
    chk("sweep_finished", finished, 1);
    chk("sweep_errors", errs, 0);
    chk("sweep_writes", idx, 19203);
    chk("sweep_done_pulses", pulses, 1);
    @(negedge clk);
    chk("sweep_idle_we", mem_we, 0);
    chk("sweep_idle_done", clear_done, 0);
    chk("sweep_idle_busy", busy, 0);

    // gated clear: grant toggles, addresses advance only on granted cycles
    mem_grant = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    prev_g = 1'b0; exp_a = 0; errs = 0; finished = 1'b0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      if (mem_we !== prev_g) errs++;
      if (mem_we) begin
        if (mem_addr !== 15'(exp_a)) errs++;
        if (exp_a == 1000) finished = 1'b1;
        exp_a++;
      end
      if (!finished) begin
        mem_grant = (cyc < 60) ? cyc[0] : 1'b1;
        prev_g = mem_grant;
      end
    end
    chk("gated_reached_1000", finished, 1);
    chk("gated_errors", errs, 0);

    // asynchronous reset mid-sweep
    #2 reset = 1'b1;
    #1;
    chk("async_we", mem_we, 0);
    chk("async_addr", mem_addr, 0);
    chk("async_data", mem_data, 0);
    chk("async_busy", busy, 0);
    chk("async_drop", drop_count, 0);
    @(negedge clk);
    reset = 1'b0; mem_grant = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; mem_grant = 1'b1;
    errs = 0; idx = 0;
    for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
      @(negedge clk);
      if (mem_we) begin
        if (mem_addr !== 15'(idx)) errs++;
        idx++;
      end
    end
    chk("restart_writes", idx, 3);
    chk("restart_errors", errs, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
